pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_flush_counter.sv | 28 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: next-PC select codes, FSM states, counter width.
package pc_sequencer_pkg;

    localparam int unsigned PC_SRC_W    = 3;
    localparam int unsigned FLUSH_CNT_W = 4;

    typedef enum logic [PC_SRC_W-1:0] {
        SRC_SEQ      = 3'b000,
        SRC_EXC      = 3'b001,
        SRC_BRANCH   = 3'b010,
        SRC_HALT     = 3'b011,
        SRC_ROLLBACK = 3'b100
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_EXC  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_flush_counter.sv
// Fetch-suppression counter used after exception entry; done_c flags the last flush cycle.
module flush_counter
    import pc_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [FLUSH_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   done_c
);

    logic [FLUSH_CNT_W-1:0] count;

    // Load wins over decrement so exception re-entry restarts the flush window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - FLUSH_CNT_W'(1);
        end
    end

    assign done_c = (count == FLUSH_CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/rollback PC update with HALT and exception flush states.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = PC_WIDTH'(1000),
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_SRC_W-1:0] PC_src,
    input  logic                pc_write,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] rollback_pc,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] PC,
    output logic                fetch_valid,
    output logic                halted,
    output logic [PC_WIDTH-1:0] epc,
    output logic                src_err
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    seq_state_e          state;
    seq_state_e          state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                epc_load;
    logic                cnt_load;
    logic                cnt_dec;
    logic                flush_done;
    logic                src_err_set;

    assign pc_inc = PC + PC_WIDTH'(1);

    // State register; status flags are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_valid <= (state_next == ST_RUN);
            halted      <= (state_next == ST_HALT);
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_next  = state;
        pc_next     = PC;
        epc_load    = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        src_err_set = 1'b0;
        case (state)
            ST_RUN: begin
                case (PC_src)
                    SRC_EXC: begin
                        pc_next    = EXC_VECTOR;
                        epc_load   = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = ST_EXC;
                    end
                    SRC_ROLLBACK: pc_next = rollback_pc;
                    SRC_HALT:     state_next = ST_HALT;
                    SRC_BRANCH: begin
                        if (pc_write) pc_next = branch_target;
                    end
                    SRC_SEQ: begin
                        if (pc_write) pc_next = pc_inc;
                    end
                    default: begin
                        src_err_set = 1'b1;
                        if (pc_write) pc_next = pc_inc;
                    end
                endcase
            end
            ST_HALT: begin
                if (PC_src == SRC_EXC) begin
                    pc_next    = EXC_VECTOR;
                    epc_load   = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = ST_EXC;
                end else if (resume) begin
                    pc_next    = pc_inc;
                    state_next = ST_RUN;
                end
            end
            ST_EXC: begin
                // Re-entry restarts the flush but keeps the original epc.
                if (PC_src == SRC_EXC) begin
                    pc_next  = EXC_VECTOR;
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (flush_done) state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // PC, exception PC and sticky illegal-select flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC      <= RESET_PC;
            epc     <= '0;
            src_err <= 1'b0;
        end else begin
            PC <= pc_next;
            if (epc_load)    epc     <= PC;
            if (src_err_set) src_err <= 1'b1;
        end
    end

    flush_counter u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (FLUSH_LOAD),
        .dec      (cnt_dec),
        .done_c   (flush_done)
    );

endmodule
